// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Times each frame plus inter-frame gap locally since the transmitter reports no busy/done.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FRAME_BITS   = 11,
  parameter int unsigned GAP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned FRAME_CYC = FRAME_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_CYC   = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned WIN_CYC   = FRAME_CYC + GAP_CYC;
  localparam int unsigned CW        = $clog2(WIN_CYC + 1);
  localparam int unsigned IW        = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [IW-1:0] last;
  logic [IW-1:0] sel_c;

  // First set request after the last winner; descending scan lets the nearest one win.
  always_comb begin
    sel_c = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      if (req[IW'((int'(last) + i) % int'(NUM_REQ))]) begin
        sel_c = IW'((int'(last) + i) % int'(NUM_REQ));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      counter  <= '0;
      last     <= IW'(NUM_REQ - 1);
      grant    <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      grant <= '0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          busy     <= 1'b0;
          tx_start <= 1'b0;
          if (|req) begin
            grant    <= NUM_REQ'(1) << sel_c;
            tx_data  <= req_data[{sel_c, 3'b000} +: 8];
            last     <= sel_c;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            counter  <= CW'(1);
            state    <= SEND;
          end
        end
        SEND: begin
          // Hold the strobe one full baud period so the baud-domain FSM sees it.
          if (counter == CW'(CLKS_PER_BIT)) begin
            tx_start <= 1'b0;
          end
          if (counter == CW'(FRAME_CYC)) begin
            if (GAP_CYC == 0) begin
              state   <= IDLE;
              busy    <= 1'b0;
              counter <= '0;
            end else begin
              state   <= GAP;
              counter <= CW'(1);
              done    <= (GAP_CYC == 1);
            end
          end else begin
            counter <= counter + CW'(1);
            done    <= (GAP_CYC == 0) && (counter == CW'(FRAME_CYC - 1));
          end
        end
        GAP: begin
          if (counter == CW'(GAP_CYC)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
          end else begin
            counter <= counter + CW'(1);
            done    <= (counter == CW'(GAP_CYC - 1));
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: window-index reference model checked every cycle,
// plus directed scenarios with hand-computed timing and data.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;

  logic [3:0] grant_a, grant_b;
  logic       tx_start_a, tx_start_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic       busy_a, busy_b, done_a, done_b;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB), .FRAME_BITS(11), .GAP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant_a), .tx_start(tx_start_a), .tx_data(tx_data_a), .busy(busy_a), .done(done_a)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB), .FRAME_BITS(11), .GAP_BITS(0)) dut_b (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant_b), .tx_start(tx_start_b), .tx_data(tx_data_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 -> GAP_BITS=1 build, index 1 -> GAP_BITS=0 build.
  // mk is the position inside the busy window (0 = idle cycle).
  int         mk[2];
  int         mlast[2];
  int         msel[2];
  logic [7:0] mdata[2];
  int         pick;

  function automatic int win(input int m);
    return (m == 0) ? (11 + 1) * CPB : 11 * CPB;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
        if (rst) begin
          mk[m] = 0; mlast[m] = NR - 1; msel[m] = 0; mdata[m] = 8'h00;
        end else if (mk[m] != 0) begin
          mk[m] = (mk[m] == win(m)) ? 0 : mk[m] + 1;
        end else if (req != 4'b0000) begin
          pick = -1;
          for (int off = 1; off <= NR; off++) begin
            if (pick < 0 && ((req >> ((mlast[m] + off) % NR)) & 4'd1) != 4'd0)
              pick = (mlast[m] + off) % NR;
          end
          msel[m]  = pick;
          mlast[m] = pick;
          mdata[m] = 8'(req_data >> (8 * pick));
          mk[m]    = 1;
        end
      end
    end
  end

  // Per-cycle comparison of both builds against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("a_grant",    int'(grant_a),    (mk[0] == 1) ? (1 << msel[0]) : 0);
        chk("a_tx_start", int'(tx_start_a), int'(mk[0] >= 1 && mk[0] <= CPB));
        chk("a_tx_data",  int'(tx_data_a),  int'(mdata[0]));
        chk("a_busy",     int'(busy_a),     int'(mk[0] != 0));
        chk("a_done",     int'(done_a),     int'(mk[0] == win(0)));
        chk("b_grant",    int'(grant_b),    (mk[1] == 1) ? (1 << msel[1]) : 0);
        chk("b_tx_start", int'(tx_start_b), int'(mk[1] >= 1 && mk[1] <= CPB));
        chk("b_tx_data",  int'(tx_data_b),  int'(mdata[1]));
        chk("b_busy",     int'(busy_b),     int'(mk[1] != 0));
        chk("b_done",     int'(done_b),     int'(mk[1] == win(1)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int nb_a, ns_a, dp_a, nb_b, ns_b, dp_b;
  int ng, t, bad, dn;
  int gt[5];
  int gv[5];
  int gd[5];
  int exp_g[5] = '{1, 2, 4, 8, 1};
  int exp_d[5] = '{'h11, 'h22, 'h33, 'h44, 'h11};

  initial begin
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_grant", int'(grant_a), 0);
    chk("rst_tx_start", int'(tx_start_a), 0);
    chk("rst_tx_data", int'(tx_data_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);

    // Single request from requester 1
    req = 4'b0010; req_data = 32'h0000A500;
    step();
    chk("single_grant", int'(grant_a), 'b0010);
    chk("single_tx_data", int'(tx_data_a), 'hA5);
    chk("single_tx_start", int'(tx_start_a), 1);
    chk("single_busy", int'(busy_a), 1);
    req = 4'b0000;
    nb_a = 1; ns_a = 1; dp_a = 0; nb_b = 1; ns_b = 1; dp_b = 0;
    for (int c = 2; c <= 55; c++) begin
      step();
      if (busy_a) nb_a++;
      if (tx_start_a) ns_a++;
      if (done_a) dp_a = c;
      if (busy_b) nb_b++;
      if (tx_start_b) ns_b++;
      if (done_b) dp_b = c;
    end
    chk("single_busy_len", nb_a, 48);
    chk("single_start_len", ns_a, 4);
    chk("single_done_cycle", dp_a, 48);
    chk("gap0_busy_len", nb_b, 44);
    chk("gap0_start_len", ns_b, 4);
    chk("gap0_done_cycle", dp_b, 44);
    chk("single_idle_after", int'(busy_a), 0);

    // All four requests held continuously from reset
    rst = 1'b1; req = 4'b1111; req_data = 32'h44332211;
    step();
    rst = 1'b0;
    ng = 0;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (grant_a != 4'b0000 && ng < 5) begin
        gt[ng] = c; gv[ng] = int'(grant_a); gd[ng] = int'(tx_data_a); ng++;
      end
    end
    chk("rr_grant_count", ng, 5);
    for (int i = 0; i < ng; i++) begin
      chk("rr_grant_order", gv[i], exp_g[i]);
      chk("rr_tx_data", gd[i], exp_d[i]);
      if (i > 0) chk("rr_spacing", gt[i] - gt[i-1], 49);
    end
    req = 4'b0000;
    repeat (50) step();

    // Late request waits for the running frame
    req = 4'b0010; req_data = 32'h0;
    step();
    chk("late_first_grant", int'(grant_a), 'b0010);
    req = 4'b0000;
    repeat (9) step();
    req = 4'b0100;
    t = 0;
    for (int c = 11; c <= 70 && t == 0; c++) begin
      step();
      if (grant_a != 4'b0000) t = c;
    end
    chk("late_grant_cycle", t, 50);
    chk("late_grant_value", int'(grant_a), 'b0100);
    req = 4'b0000;
    repeat (55) step();

    // Data captured at grant is immune to later req_data changes
    req = 4'b0001; req_data = 32'h0000005A;
    step();
    chk("stable_grant", int'(grant_a), 'b0001);
    chk("stable_tx_data", int'(tx_data_a), 'h5A);
    req = 4'b0000;
    step(); step();
    req_data = 32'h000000FF;
    bad = 0; dn = 0;
    for (int c = 4; c <= 48; c++) begin
      step();
      if (tx_data_a != 8'h5A) bad++;
      if (done_a) dn = c;
    end
    chk("stable_changes", bad, 0);
    chk("stable_done_cycle", dn, 48);
    repeat (5) step();

    // Reset in the middle of a frame
    req = 4'b0001; req_data = 32'h000000C3;
    step();
    chk("midrst_grant", int'(grant_a), 'b0001);
    req = 4'b0000;
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_grant_clr", int'(grant_a), 0);
    chk("midrst_busy", int'(busy_a), 0);
    chk("midrst_tx_start", int'(tx_start_a), 0);
    chk("midrst_tx_data", int'(tx_data_a), 0);
    chk("midrst_done", int'(done_a), 0);
    req = 4'b1001;
    step();
    chk("postrst_first", int'(grant_a), 'b0001);
    req = 4'b1000;
    t = 0;
    for (int c = 2; c <= 60 && t == 0; c++) begin
      step();
      if (grant_a != 4'b0000) t = c;
    end
    chk("postrst_spacing", t, 50);
    chk("postrst_second", int'(grant_a), 'b1000);
    req = 4'b0000;
    repeat (50) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
